// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial WIDTH-bit adder. It uses one full-adder cell and a
// registered carry, and processes one bit per clock, LSB first.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add a `sub` input.
//   sub=1 computes a-b as a + ~b + 1, and cin is ignored.
//   In that mode cout=1 means no borrow.
//
// Handshake: start is sampled only in IDLE, and an accepted start captures a/b/cin
// (and sub). While the sum is being formed, busy stays high for exactly WIDTH
// cycles. done then pulses high for one cycle. sum/cout are valid from that
// cycle and hold until the next completion. A start seen in RUN or DONE is
// dropped, not queued. state_dbg mirrors the FSM state (0=IDLE, 1=RUN, 2=DONE).
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;
  logic             fa_bit;
  logic             fa_carry;
  logic [WIDTH-1:0] sum_shift;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  assign accept   = (state == S_IDLE) && start;
  assign last_bit = (state == S_RUN) && (cnt == LAST_CNT);

  // The single full-adder cell works on the current LSBs and the stored carry.
  assign fa_bit    = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_carry  = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign sum_shift = {fa_bit, sum_sr[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert b and force the carry-in to 1.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == LAST_CNT) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operands are captured on accept and shifted right one bit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b_load;
      sum_sr <= '0;
      carry  <= carry_load;
      cnt    <= '0;
    end else if (state == S_RUN) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr <= sum_shift;
      carry  <= fa_carry;
      cnt    <= cnt + CW'(1);
    end
  end

  // Result registers: these update only on the completion edge, so they hold through a RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last_bit) begin
      sum  <= sum_shift;
      cout <= fa_carry;
    end
  end

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: directed-vector bench for serial_adder_seq (WIDTH=8).
module tb_serial_adder_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: expected {cout,sum} per launched operation.
  logic [WIDTH:0] exp_q[$];
  // Last completed result, which sum/cout must hold during a RUN.
  logic [WIDTH:0] last_res = '0;

  serial_adder_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Compare the completed result against the scoreboard head.
  task automatic sb_compare(input string tag);
    logic [WIDTH:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {cout, sum}, e);
      last_res = e;
    end
  endtask

  // Launch one operation from IDLE, then watch busy, the held outputs and the done pulse.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic tcin, input logic [WIDTH:0] expv);
    int cyc;
    int busy_cyc;
    exp_q.push_back(expv);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    busy_cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cyc++;
      check({tag, "_hold"}, {cout, sum}, last_res);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_busy_cycles"}, busy_cyc, WIDTH);
    if (done) sb_compare(tag);
    else void'(exp_q.pop_front());
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int cyc;
    int done_cnt;
    int prev_idx;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy",  busy, 1'b0);
    check("rst_done",  done, 1'b0);
    check("rst_sum",   sum, '0);
    check("rst_cout",  cout, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add and carry/wrap cases.
    do_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 9'h08D);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100);
    do_op("add_ff_cin", 8'hFF, 8'h00, 1'b1, 9'h100);
    do_op("add_c8_64", 8'hC8, 8'h64, 1'b1, 9'h12D);

    // A start during RUN must be ignored.
    exp_q.push_back(9'h010);
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) sb_compare("ign_start");
      end
      @(negedge clk);
    end
    check("ign_done_count", done_cnt, 1);

    // Start held high gives back-to-back operations every WIDTH+2 cycles.
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    done_cnt = 0;
    prev_idx = -1;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (busy) check("b2b_hold", {cout, sum}, last_res);
      if (done) begin
        done_cnt++;
        check("b2b_result", {cout, sum}, 9'h100);
        last_res = 9'h100;
        if (prev_idx >= 0) check("b2b_period", i - prev_idx, WIDTH + 2);
        prev_idx = i;
      end
    end
    start = 1'b0;
    check("b2b_done_count", done_cnt, 3);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_drain_done", done, 1'b1);
    check("b2b_drain_result", {cout, sum}, 9'h100);
    @(negedge clk);
    check("b2b_idle", state_dbg, 2'd0);

    // An asynchronous reset in the middle of a RUN clears the outputs at once.
    a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_sum",  sum, '0);
    check("arst_cout", cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("arst_no_done", done_cnt, 0);
    last_res = '0;
    do_op("post_rst", 8'hF0, 8'h20, 1'b0, 9'h110);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    do_op("sub_10_01", 8'h10, 8'h01, 1'b0, 9'h10F);
    do_op("sub_01_02", 8'h01, 8'h02, 1'b1, 9'h0FF);
    do_op("sub_33_33", 8'h33, 8'h33, 1'b0, 9'h100);
    sub = 1'b0;
    do_op("sub_off_add", 8'h01, 8'h01, 1'b1, 9'h003);
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
